// File: rtl/ext_unit.sv
// Immediate-extension stage: widens imm16 to 32 bits (zero/sign/LUI) and registers it with a valid tag.
// Optional macro EXT_COMB_OUT_EN adds the unregistered ext32_comb output for bypass use.
module ext_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        valid_in,
  input  logic [15:0] imm16,
  input  logic        extop,
  input  logic        luiop,
  output logic [31:0] ext32,
  output logic        valid_out
`ifdef EXT_COMB_OUT_EN
  ,
  output logic [31:0] ext32_comb
`endif
);

  logic [31:0] ext_d;
  logic [31:0] ext_q;
  logic        valid_d;
  logic        valid_q;

  // LUI placement takes priority over the sign/zero selection.
  always_comb begin
    ext_d = {16'h0000, imm16};
    if (luiop) begin
      ext_d = {imm16, 16'h0000};
    end else if (extop) begin
      ext_d = {{16{imm16[15]}}, imm16};
    end
  end

  // Data is loaded regardless of valid_in; consumers qualify with valid_out.
  always_comb begin
    valid_d = valid_q;
    if (en) begin
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else if (en) begin
      ext_q   <= ext_d;
      valid_q <= valid_d;
    end
  end

  assign ext32     = ext_q;
  assign valid_out = valid_q;

`ifdef EXT_COMB_OUT_EN
  assign ext32_comb = ext_d;
`endif

endmodule

// File: tb/tb_ext_unit.sv
// Directed self-checking bench for ext_unit; checks ext32_comb too when EXT_COMB_OUT_EN is defined.
module tb_ext_unit;

  logic        clk;
  logic        reset;
  logic        en;
  logic        valid_in;
  logic [15:0] imm16;
  logic        extop;
  logic        luiop;
  logic [31:0] ext32;
  logic        valid_out;
`ifdef EXT_COMB_OUT_EN
  logic [31:0] ext32_comb;
`endif

  int n_cmp;
  int n_err;

  ext_unit dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .valid_in  (valid_in),
    .imm16     (imm16),
    .extop     (extop),
    .luiop     (luiop),
    .ext32     (ext32),
    .valid_out (valid_out)
`ifdef EXT_COMB_OUT_EN
    ,
    .ext32_comb(ext32_comb)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; valid_in = 1'b1; imm16 = 16'hFFFF; extop = 1'b1; luiop = 1'b0;
    step();
    n_cmp++;
    if (ext32 !== 32'h0) begin
      n_err++; $display("FAIL reset_ext32: got %h want %h", ext32, 32'h0);
    end
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_valid: got %b want 0", valid_out);
    end
    step();
    n_cmp++;
    if (ext32 !== 32'h0 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset_hold: got %h/%b want 0/0", ext32, valid_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero_sign();
    en = 1'b1; valid_in = 1'b1; imm16 = 16'h8001; extop = 1'b0; luiop = 1'b0;
    step();
    n_cmp++;
    if (ext32 !== 32'h0000_8001) begin
      n_err++; $display("FAIL zero_ext_8001: got %h want %h", ext32, 32'h0000_8001);
    end
    n_cmp++;
    if (valid_out !== 1'b1) begin
      n_err++; $display("FAIL zero_ext_valid: got %b want 1", valid_out);
    end
    extop = 1'b1;
    step();
    n_cmp++;
    if (ext32 !== 32'hFFFF_8001) begin
      n_err++; $display("FAIL sign_ext_8001: got %h want %h", ext32, 32'hFFFF_8001);
    end
  endtask

  task automatic test_boundary();
    en = 1'b1; valid_in = 1'b1; luiop = 1'b0;
    imm16 = 16'h8000; extop = 1'b1;
    step();
    n_cmp++;
    if (ext32 !== 32'hFFFF_8000) begin
      n_err++; $display("FAIL sign_8000: got %h want %h", ext32, 32'hFFFF_8000);
    end
    extop = 1'b0;
    step();
    n_cmp++;
    if (ext32 !== 32'h0000_8000) begin
      n_err++; $display("FAIL zero_8000: got %h want %h", ext32, 32'h0000_8000);
    end
    imm16 = 16'h7FFF; extop = 1'b0;
    step();
    n_cmp++;
    if (ext32 !== 32'h0000_7FFF) begin
      n_err++; $display("FAIL zero_7fff: got %h want %h", ext32, 32'h0000_7FFF);
    end
    extop = 1'b1;
    step();
    n_cmp++;
    if (ext32 !== 32'h0000_7FFF) begin
      n_err++; $display("FAIL sign_7fff: got %h want %h", ext32, 32'h0000_7FFF);
    end
  endtask

  task automatic test_lui();
    en = 1'b1; valid_in = 1'b1; imm16 = 16'h1234; extop = 1'b1; luiop = 1'b1;
    step();
    n_cmp++;
    if (ext32 !== 32'h1234_0000) begin
      n_err++; $display("FAIL lui_priority: got %h want %h", ext32, 32'h1234_0000);
    end
    imm16 = 16'hF00D; extop = 1'b0;
    step();
    n_cmp++;
    if (ext32 !== 32'hF00D_0000) begin
      n_err++; $display("FAIL lui_zero_mode: got %h want %h", ext32, 32'hF00D_0000);
    end
    luiop = 1'b0;
  endtask

  task automatic test_stall();
    en = 1'b1; valid_in = 1'b1; imm16 = 16'h7FFF; extop = 1'b1; luiop = 1'b0;
    step();
    n_cmp++;
    if (ext32 !== 32'h0000_7FFF) begin
      n_err++; $display("FAIL stall_load: got %h want %h", ext32, 32'h0000_7FFF);
    end
    en = 1'b0; imm16 = 16'hABCD; valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (ext32 !== 32'h0000_7FFF || valid_out !== 1'b1) begin
        n_err++; $display("FAIL stall_hold_%0d: got %h/%b want %h/1", i, ext32, valid_out, 32'h0000_7FFF);
      end
    end
    en = 1'b1; valid_in = 1'b1;
    step();
    n_cmp++;
    if (ext32 !== 32'hFFFF_ABCD) begin
      n_err++; $display("FAIL stall_release: got %h want %h", ext32, 32'hFFFF_ABCD);
    end
  endtask

  task automatic test_reset_mid_stall();
    en = 1'b0; imm16 = 16'h5555; valid_in = 1'b1;
    step();
    n_cmp++;
    if (ext32 !== 32'hFFFF_ABCD || valid_out !== 1'b1) begin
      n_err++; $display("FAIL midstall_pre: got %h/%b want %h/1", ext32, valid_out, 32'hFFFF_ABCD);
    end
    reset = 1'b1;
    step();
    n_cmp++;
    if (ext32 !== 32'h0 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL midstall_reset: got %h/%b want 0/0", ext32, valid_out);
    end
    reset = 1'b0;
    step();
    n_cmp++;
    if (ext32 !== 32'h0 || valid_out !== 1'b0) begin
      n_err++; $display("FAIL midstall_after: got %h/%b want 0/0", ext32, valid_out);
    end
    en = 1'b1; extop = 1'b0;
    step();
    n_cmp++;
    if (ext32 !== 32'h0000_5555 || valid_out !== 1'b1) begin
      n_err++; $display("FAIL midstall_resume: got %h/%b want %h/1", ext32, valid_out, 32'h0000_5555);
    end
  endtask

  task automatic test_valid_tag();
    en = 1'b1; luiop = 1'b0; extop = 1'b1; imm16 = 16'h0042; valid_in = 1'b0;
    step();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL valid_idle: got %b want 0", valid_out);
    end
    n_cmp++;
    if (ext32 !== 32'h0000_0042) begin
      n_err++; $display("FAIL data_ungated: got %h want %h", ext32, 32'h0000_0042);
    end
    valid_in = 1'b1; imm16 = 16'h9000;
`ifdef EXT_COMB_OUT_EN
    #1;
    n_cmp++;
    if (ext32_comb !== 32'hFFFF_9000) begin
      n_err++; $display("FAIL comb_sign: got %h want %h", ext32_comb, 32'hFFFF_9000);
    end
    luiop = 1'b1;
    #1;
    n_cmp++;
    if (ext32_comb !== 32'h9000_0000) begin
      n_err++; $display("FAIL comb_lui: got %h want %h", ext32_comb, 32'h9000_0000);
    end
    luiop = 1'b0;
`endif
    step();
    n_cmp++;
    if (valid_out !== 1'b1) begin
      n_err++; $display("FAIL valid_pulse: got %b want 1", valid_out);
    end
    valid_in = 1'b0;
    step();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL valid_drop: got %b want 0", valid_out);
    end
    step();
    n_cmp++;
    if (valid_out !== 1'b0) begin
      n_err++; $display("FAIL valid_stay: got %b want 0", valid_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v_imm [6];
    logic        v_ext [6];
    logic        v_lui [6];
    logic [31:0] v_exp [6];
    v_imm = '{16'h0001, 16'hFFFF, 16'hFFFF, 16'hC3A5, 16'h0000, 16'h8F0F};
    v_ext = '{1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b1};
    v_lui = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
    v_exp = '{32'h0000_0001, 32'h0000_FFFF, 32'hFFFF_FFFF,
              32'hC3A5_0000, 32'h0000_0000, 32'hFFFF_8F0F};
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      imm16 = v_imm[i]; extop = v_ext[i]; luiop = v_lui[i]; valid_in = i[0];
      step();
      n_cmp++;
      if (ext32 !== v_exp[i] || valid_out !== i[0]) begin
        n_err++; $display("FAIL b2b_%0d: got %h/%b want %h/%b", i, ext32, valid_out, v_exp[i], i[0]);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1; en = 1'b0; valid_in = 1'b0; imm16 = 16'h0; extop = 1'b0; luiop = 1'b0;
    #2;
    test_reset();
    test_zero_sign();
    test_boundary();
    test_lui();
    test_stall();
    test_reset_mid_stall();
    test_valid_tag();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
